// File: rtl/imm_narrow_packer.sv
// Narrows a 64-bit signed value into a signed WIDTH-bit field behind a 2-entry valid/ready buffer.
// Optional build macro IMM_NARROW_SAT_EN: saturate out-of-range values instead of truncating.
module imm_narrow_packer #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_field,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    // Returns {ovf, field}; a value fits when every bit above the field's sign bit matches it.
    function automatic logic [WIDTH:0] narrow(input logic [63:0] v);
        logic             fits;
        logic [WIDTH-1:0] f;
        fits = (&v[63:WIDTH-1]) | ~(|v[63:WIDTH-1]);
`ifdef IMM_NARROW_SAT_EN
        if (fits) begin
            f = v[WIDTH-1:0];
        end else if (v[63]) begin
            f = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            f = {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        f = v[WIDTH-1:0];
`endif
        return {~fits, f};
    endfunction

    logic [WIDTH:0]   entry_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic [CNT_W-1:0] ovf_count_r;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH:0]   packed_s;
    logic [WIDTH:0]   head_s;

    // Handshake decode and head selection; outputs read as zero while the buffer is empty.
    always_comb begin
        in_ready  = (count_r != 2'd2);
        out_valid = (count_r != 2'd0);
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        packed_s  = narrow(in_data);
        head_s    = entry_r[rd_ptr_r];
        if (out_valid) begin
            out_field = head_s[WIDTH-1:0];
            out_ovf   = head_s[WIDTH];
        end else begin
            out_field = {WIDTH{1'b0}};
            out_ovf   = 1'b0;
        end
        ovf_count = ovf_count_r;
    end

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_r[0] <= {(WIDTH+1){1'b0}};
            entry_r[1] <= {(WIDTH+1){1'b0}};
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            if (push_s) begin
                entry_r[wr_ptr_r] <= packed_s;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of accepted out-of-range values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count_r <= {CNT_W{1'b0}};
        end else if (push_s && packed_s[WIDTH] && (ovf_count_r != {CNT_W{1'b1}})) begin
            ovf_count_r <= ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_imm_narrow_packer.sv
// Directed, table-driven bench for imm_narrow_packer (WIDTH=9, CNT_W=4).
module tb_imm_narrow_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_field;
    logic        out_ovf;
    logic [3:0]  ovf_count;

    int checks;
    int errors;
    int exp_cnt;

    typedef struct {
        logic [63:0] data;
        logic [8:0]  fld_trunc;
        logic [8:0]  fld_sat;
        logic        ovf;
    } vec_t;

    vec_t vecs [11];

    imm_narrow_packer #(.WIDTH(9), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [8:0] sel(input logic [8:0] t, input logic [8:0] s);
`ifdef IMM_NARROW_SAT_EN
        return s;
`else
        return t;
`endif
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        out_ready = 1'b1;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FF9C, 9'h19C, 9'h19C, 1'b0};
        vecs[1]  = '{64'h0000_0000_0000_00FF, 9'h0FF, 9'h0FF, 1'b0};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FF00, 9'h100, 9'h100, 1'b0};
        vecs[3]  = '{64'h0000_0000_0000_012C, 9'h12C, 9'h0FF, 1'b1};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FED4, 9'h0D4, 9'h100, 1'b1};
        vecs[5]  = '{64'h0000_0000_0000_0100, 9'h100, 9'h0FF, 1'b1};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FEFF, 9'h0FF, 9'h100, 1'b1};
        vecs[7]  = '{64'h0000_0000_0000_0000, 9'h000, 9'h000, 1'b0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 9'h1FF, 9'h1FF, 1'b0};
        vecs[9]  = '{64'h8000_0000_0000_0000, 9'h000, 9'h100, 1'b1};
        vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 9'h1FF, 9'h0FF, 1'b1};

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_field", {55'd0, out_field}, 64'd0);
        check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        check("rst_ovf_count", {60'd0, ovf_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table: push one value, check the head one cycle later, then let it drain.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            step();
            in_valid = 1'b0;
            in_data  = 64'h0123_4567_89AB_CDEF;
            if (vecs[i].ovf && exp_cnt != 15) exp_cnt++;
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_field", i), {55'd0, out_field},
                  {55'd0, sel(vecs[i].fld_trunc, vecs[i].fld_sat)});
            check($sformatf("vec%0d_ovf", i), {63'd0, out_ovf}, {63'd0, vecs[i].ovf});
            check($sformatf("vec%0d_cnt", i), {60'd0, ovf_count}, exp_cnt);
            step();
            check($sformatf("vec%0d_drain", i), {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: two fill the buffer, the third waits for space.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd11;
        step();
        check("bp_ready1", {63'd0, in_ready}, 64'd1);
        in_data = 64'd22;
        step();
        check("bp_ready2", {63'd0, in_ready}, 64'd0);
        in_data = 64'd33;
        step();
        check("bp_held_ready", {63'd0, in_ready}, 64'd0);
        check("bp_head_a", {55'd0, out_field}, 64'd11);
        out_ready = 1'b1;
        step();
        check("bp_head_b", {55'd0, out_field}, 64'd22);
        check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_data  = 64'd99;
        check("bp_head_c", {55'd0, out_field}, 64'd33);
        check("bp_valid_c", {63'd0, out_valid}, 64'd1);
        step();
        check("bp_empty", {63'd0, out_valid}, 64'd0);

        // Buffered entries ignore in_data while not pushing.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd77;
        step();
        in_valid = 1'b0;
        in_data  = 64'd5;
        step();
        check("hold_field", {55'd0, out_field}, 64'd77);
        out_ready = 1'b1;
        step();

        // Steady stream: head is always the value pushed on the previous edge.
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 64'(40 + k * 3);
            step();
            check($sformatf("stream%0d_field", k), {55'd0, out_field}, 64'(40 + k * 3));
            check($sformatf("stream%0d_ready", k), {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Counter saturation: drive until it must hold at 15.
        in_valid = 1'b1;
        in_data  = 64'd300;
        for (int k = 0; k < 20; k++) begin
            step();
            if (exp_cnt != 15) exp_cnt++;
        end
        in_valid = 1'b0;
        check("sat_cnt", {60'd0, ovf_count}, exp_cnt);
        check("sat_cnt_max", {60'd0, ovf_count}, 64'd15);
        step();

        // Asynchronous reset with the buffer full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd1000;
        step();
        step();
        in_valid = 1'b0;
        check("full_before_rst", {63'd0, in_ready}, 64'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_ovf_count", {60'd0, ovf_count}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_empty", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
